// File: rtl/key_round_sequencer.sv
// key_round_sequencer: on-the-fly AES-128 key expansion feeding a single-round
// cipher stage. One new key word is generated per cycle. Each finished round key
// is presented as four row words with its round number and a one-cycle strobe.
module key_round_sequencer #(
    parameter int NR          = 10,
    parameter bit EMIT_ROUND0 = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stall,
    input  logic [31:0] key_w0,
    input  logic [31:0] key_w1,
    input  logic [31:0] key_w2,
    input  logic [31:0] key_w3,
    output logic [31:0] k1,
    output logic [31:0] k2,
    output logic [31:0] k3,
    output logic [31:0] k4,
    output logic [3:0]  round,
    output logic        key_flag,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        EMIT = 2'd2,
        FIN  = 2'd3
    } state_t;

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    // FIPS-197 forward S-box
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    state_t      state;
    logic [1:0]  idx;
    logic [7:0]  rcon;
    logic [3:0]  rnd_cnt;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [31:0] w3;

    logic [31:0] rot_sub;
    logic [31:0] t_word;
    logic [31:0] cur_word;
    logic [31:0] new_word;

    // GF(2^8) doubling used to advance the round constant
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Column-ordered words to row words: row j collects byte j of every column
    function automatic logic [127:0] transpose(input logic [31:0] a, input logic [31:0] b,
                                               input logic [31:0] c, input logic [31:0] d);
        return {a[31:24], b[31:24], c[31:24], d[31:24],
                a[23:16], b[23:16], c[23:16], d[23:16],
                a[15:8],  b[15:8],  c[15:8],  d[15:8],
                a[7:0],   b[7:0],   c[7:0],   d[7:0]};
    endfunction

    // Word generator: word idx of the current round is rebuilt from its old
    // value and either the transformed last word (idx 0) or the word just before it
    always_comb begin
        rot_sub  = {SBOX[w3[23:16]], SBOX[w3[15:8]], SBOX[w3[7:0]], SBOX[w3[31:24]]};
        t_word   = rot_sub ^ {rcon, 24'h0};
        cur_word = w0;
        case (idx)
            2'd0: begin
                cur_word = w0;
                t_word   = rot_sub ^ {rcon, 24'h0};
            end
            2'd1: begin
                cur_word = w1;
                t_word   = w0;
            end
            2'd2: begin
                cur_word = w2;
                t_word   = w1;
            end
            default: begin
                cur_word = w3;
                t_word   = w2;
            end
        endcase
        new_word = cur_word ^ t_word;
    end

    // A key is only visible to the downstream on cycles where it can actually advance
    assign key_flag = (state == EMIT) && !stall;

    // Sequencer FSM with key registers and registered outputs; stall freezes everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= 2'd0;
            rcon    <= 8'h00;
            rnd_cnt <= 4'd0;
            w0      <= 32'h0;
            w1      <= 32'h0;
            w2      <= 32'h0;
            w3      <= 32'h0;
            k1      <= 32'h0;
            k2      <= 32'h0;
            k3      <= 32'h0;
            k4      <= 32'h0;
            round   <= 4'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else if (!stall) begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        w0      <= key_w0;
                        w1      <= key_w1;
                        w2      <= key_w2;
                        w3      <= key_w3;
                        rcon    <= 8'h01;
                        rnd_cnt <= 4'd0;
                        idx     <= 2'd0;
                        busy    <= 1'b1;
                        if (EMIT_ROUND0) begin
                            state            <= EMIT;
                            round            <= 4'd0;
                            {k1, k2, k3, k4} <= transpose(key_w0, key_w1, key_w2, key_w3);
                        end else begin
                            state <= GEN;
                        end
                    end
                end
                GEN: begin
                    case (idx)
                        2'd0:    w0 <= new_word;
                        2'd1:    w1 <= new_word;
                        2'd2:    w2 <= new_word;
                        default: w3 <= new_word;
                    endcase
                    idx <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        rcon             <= xtime(rcon);
                        rnd_cnt          <= rnd_cnt + 4'd1;
                        round            <= rnd_cnt + 4'd1;
                        {k1, k2, k3, k4} <= transpose(w0, w1, w2, new_word);
                        state            <= EMIT;
                    end
                end
                EMIT: begin
                    idx <= 2'd0;
                    if (rnd_cnt == LAST_ROUND) begin
                        state <= FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= GEN;
                    end
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
